// File: rtl/digito_pkg.sv
`default_nettype none
// ============================================================================
// Package  : digito_pkg
// Purpose  : Shared BCD digit type and constants for the display path.
// Revision : 1.0 - initial release
// ============================================================================
package digito_pkg;

   // One displayed digit: BCD value plus decimal point.
   typedef struct packed {
      logic [3:0] digito;
      logic       dp;
   } BCDnumber_t;

   localparam BCDnumber_t BCD_CERO = '{digito: 4'd0, dp: 1'b0};

   // A digit counts as "zero" for blanking only if its decimal point is off too.
   function automatic logic is_zero(input BCDnumber_t d);
      return (d.digito == 4'd0) && !d.dp;
   endfunction

endpackage
`default_nettype wire

// File: rtl/digit_blank_mask.sv
`default_nettype none
// ============================================================================
// Module   : digit_blank_mask
// Purpose  : Leading-zero blanking mask. Digit i is blanked when blanking is
//            enabled, i is not the least-significant digit, and every digit
//            from i upward is zero with its decimal point off.
// Revision : 1.0 - initial release
// ============================================================================
module digit_blank_mask
   import digito_pkg::*;
#(
   parameter int NRO_DIGITOS = 6
) (
   input  BCDnumber_t [NRO_DIGITOS-1:0] num_s,
   input  logic                         lz_s,
   output logic [NRO_DIGITOS-1:0]       blank_mask
);

   logic [NRO_DIGITOS-1:0] zero_suffix;
   logic                   run;

   // Suffix-AND of zero digits, walking down from the most significant one.
   always_comb begin
      zero_suffix = '0;
      run         = 1'b1;
      for (int i = NRO_DIGITOS - 1; i >= 0; i--) begin
         run            = run & is_zero(num_s[i]);
         zero_suffix[i] = run;
      end
   end

   // Digit 0 always stays visible so a zero value still shows "0".
   assign blank_mask = {zero_suffix[NRO_DIGITOS-1:1] & {(NRO_DIGITOS-1){lz_s}}, 1'b0};

endmodule
`default_nettype wire

// File: rtl/digit_scanner.sv
`default_nettype none
// ============================================================================
// Module   : digit_scanner
// Purpose  : Time-multiplexed common-anode digit driver with PWM brightness,
//            per-digit blink, leading-zero blanking and per-frame snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module digit_scanner
   import digito_pkg::*;
#(
   parameter int NRO_DIGITOS = 6,
   parameter int PWM_STEPS   = 8,
   parameter int BLINK_DIV   = 64
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 tick,
   input  BCDnumber_t [NRO_DIGITOS-1:0]         num,
   input  logic [$clog2(PWM_STEPS+1)-1:0]       brillo,
   input  logic [NRO_DIGITOS-1:0]               blink_mask,
   input  logic                                 blank_lz,
   output logic [NRO_DIGITOS-1:0]               out_digit_select,
   output BCDnumber_t                           out_digit_number,
   output logic                                 frame_start
);

   localparam int SUB_W = $clog2(PWM_STEPS);
   localparam int IDX_W = $clog2(NRO_DIGITOS);
   localparam int BRI_W = $clog2(PWM_STEPS + 1);
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PWM_STEPS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NRO_DIGITOS - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

   // Scan and blink state
   logic [SUB_W-1:0] sub,       sub_nxt;
   logic [IDX_W-1:0] idx,       idx_nxt;
   logic [BLK_W-1:0] blink_cnt, blink_cnt_nxt;
   logic             blink_phase, blink_phase_nxt;
   logic             frame_end;

   // Frame-coherent snapshot of the display inputs
   BCDnumber_t [NRO_DIGITOS-1:0] num_s;
   logic [NRO_DIGITOS-1:0]       mask_s;
   logic                         lz_s;

   logic [NRO_DIGITOS-1:0] blank_mask;
   logic                   lit;
   logic [NRO_DIGITOS-1:0] select_nxt;
   BCDnumber_t             number_nxt;

   digit_blank_mask #(
      .NRO_DIGITOS (NRO_DIGITOS)
   ) u_blank (
      .num_s      (num_s),
      .lz_s       (lz_s),
      .blank_mask (blank_mask)
   );

   // Next scan position and blink divider; everything advances only on tick.
   always_comb begin
      sub_nxt         = sub;
      idx_nxt         = idx;
      blink_cnt_nxt   = blink_cnt;
      blink_phase_nxt = blink_phase;
      frame_end       = 1'b0;
      if (tick) begin
         if (sub == SUB_LAST) begin
            sub_nxt = '0;
            if (idx == IDX_LAST) begin
               idx_nxt   = '0;
               frame_end = 1'b1;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end else begin
            sub_nxt = sub + 1'b1;
         end
      end
      if (frame_end) begin
         if (blink_cnt == BLK_LAST) begin
            blink_cnt_nxt   = '0;
            blink_phase_nxt = ~blink_phase;
         end else begin
            blink_cnt_nxt = blink_cnt + 1'b1;
         end
      end
   end

   // State and snapshot registers; the snapshot reloads only at frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub         <= '0;
         idx         <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         num_s       <= {NRO_DIGITOS{BCD_CERO}};
         mask_s      <= '0;
         lz_s        <= 1'b0;
      end else begin
         sub         <= sub_nxt;
         idx         <= idx_nxt;
         blink_cnt   <= blink_cnt_nxt;
         blink_phase <= blink_phase_nxt;
         if (frame_end) begin
            num_s  <= num;
            mask_s <= blink_mask;
            lz_s   <= blank_lz;
         end
      end
   end

   // Decide whether the current digit is lit and form the display values.
   // Brightness saturates naturally: sub never reaches PWM_STEPS.
   always_comb begin
      lit = (BRI_W'(sub) < brillo) && !blank_mask[idx] && !(mask_s[idx] && blink_phase);
      select_nxt = '1;
      number_nxt = BCD_CERO;
      if (lit) begin
         select_nxt[idx] = 1'b0;
         number_nxt      = num_s[idx];
      end
   end

   // Registered outputs, one clock behind the scan state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_digit_select <= '1;
         out_digit_number <= BCD_CERO;
         frame_start      <= 1'b0;
      end else begin
         out_digit_select <= select_nxt;
         out_digit_number <= number_nxt;
         frame_start      <= frame_end;
      end
   end

endmodule
`default_nettype wire
